conv_window_sched: RTL and testbench
====================================

// Module: conv_window_sched
// PURPOSE
//  Scheduler for the 3x3 convolution datapath. Walks the IMG_W x IMG_H input image in raster order.
//  For each output pixel it issues 9 tap addresses (row-major, zero-padded at edges) to the image ROM
//  and MAC, waits for the MAC pipeline to drain, then writes the result to layer memory L0.
//  The L0 write port is shared with the pooling engine, so every write goes through a req/gnt arbiter.
// PARAMETERS
//  IMG_W    64  image width in pixels; must be a power of two
//  IMG_H    64  image height in pixels; must be a power of two
//  AW       12  address width; log2(IMG_W*IMG_H)
//  MAC_LAT  2   cycles from the last tap to a valid MAC result (>=1)
// PORTS
//  clk        in   1   clock; all state updates on the rising edge
//  reset      in   1   asynchronous, active-low reset
//  start      in   1   1-cycle request to begin a frame; honoured only in IDLE
//  wr_gnt     in   1   arbiter grant for the L0 write port
//  iaddr      out  AW  image ROM tap address
//  tap_valid  out  1   a tap is presented this cycle
//  tap_zero   out  1   current tap is padding; the MAC substitutes 0 for idata
//  tap_idx    out  4   tap index 0..8
//  acc_clr    out  1   clear the MAC accumulator; asserted together with tap 0
//  wr_req     out  1   request the L0 write port
//  res_addr   out  AW  L0 write address = y*IMG_W + x
//  busy       out  1   frame in progress
//  done       out  1   1-cycle pulse when the last pixel is written
// BEHAVIOUR
//  - Reset (asynchronous, reset==0): state=IDLE, x=y=0. Every output is 0.
//  - FSM states: IDLE -> FETCH -> DRAIN -> WRITE -> (FETCH | DONE) -> IDLE. All outputs are registered.
//  - IDLE: start=1 moves to FETCH next cycle and sets busy=1. busy stays 1 until the cycle done pulses.
//  - FETCH: 9 consecutive cycles with tap_valid=1 and tap_idx=k, k=0..8.
//      dy = k/3 - 1, dx = k%3 - 1. Signed neighbour coordinates: yy=y+dy, xx=x+dx.
//      In bounds (0<=yy<IMG_H and 0<=xx<IMG_W): iaddr = yy*IMG_W + xx, tap_zero=0.
//      Out of bounds: tap_zero=1 and iaddr = y*IMG_W + x, so the address never wraps.
//      Use (AW/2+1)-bit signed compares; no modulo wrap-around at the edges.
//  - DRAIN: MAC_LAT cycles with tap_valid=0.
//  - WRITE: wr_req=1 and res_addr = y*IMG_W + x. Both are held stable until a cycle with wr_gnt=1.
//      In the grant cycle, wr_req drops on the next edge and the pixel advances (x+1; at x=IMG_W-1, x=0 and y+1).
//      If the written pixel was the last one (IMG_W*IMG_H-1), go to DONE. Otherwise go to FETCH.
//  - A wr_gnt arriving outside WRITE is ignored.
//  - DONE: done=1 and busy=0 for one cycle, then IDLE.
//  - start while busy: ignored, with no effect on counters.
//  - Throughput with wr_gnt tied to 1: 9+MAC_LAT+1 cycles per pixel, i.e. 12 at defaults.
//  - Reset mid-frame: immediate abort. No partial write is retried, and start must be re-issued.
// CONFIGURATION
//  CONV_SCHED_PERF_EN defined:
//    - Adds output perf_stall [15:0]: counts cycles in WRITE with wr_gnt=0.
//    - The count saturates at 16'hFFFF.
//    - It clears on reset and on an accepted start, and holds its value after done.
//  CONV_SCHED_PERF_EN undefined: the port and the counter do not exist. No other behaviour changes.
// TESTING
//  1. Pixel (0,0), wr_gnt=1:
//     - tap_zero=1 for k=0,1,2,3,6.
//     - iaddr = 0, 1, 64, 65 for k = 4, 5, 7, 8.
//     - acc_clr only with k=0; res_addr=0.
//  2. Pixel (1,1): iaddr sequence 0,1,2,64,65,66,128,129,130, with tap_zero=0 throughout.
//  3. Pixel (63,63), i.e. x=63, y=63: tap_zero=1 for k=2,5,6,7,8; res_addr=4095.
//     Then done pulses exactly once, busy=0, and the FSM is in IDLE.
//  4. wr_gnt held low for 3 cycles in WRITE:
//     - wr_req stays 1 with res_addr unchanged, and tap_valid=0.
//     - The advance happens only on the grant cycle. With PERF_EN, perf_stall=3.
//  5. Full frame with wr_gnt=1: start to done takes 4096*12 cycles.
//     A start pulsed mid-frame is ignored, and the frame length is unchanged.
//  6. reset=0 asserted in FETCH of pixel 100:
//     - All outputs go to 0 immediately.
//     - After release and start, the first pixel is (0,0).

Source files
------------

// File: rtl/conv_window_sched.sv
// Raster-order scheduler for the 3x3 convolution: issues 9 zero-padded taps per pixel, waits out
// the MAC latency, then writes the result to L0 through a req/gnt handshake. Optional: CONV_SCHED_PERF_EN.
module conv_window_sched #(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int AW      = 12,
    parameter int MAC_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          wr_gnt,
    output logic [AW-1:0] iaddr,
    output logic          tap_valid,
    output logic          tap_zero,
    output logic [3:0]    tap_idx,
    output logic          acc_clr,
    output logic          wr_req,
    output logic [AW-1:0] res_addr,
    output logic          busy,
`ifdef CONV_SCHED_PERF_EN
    output logic [15:0]   perf_stall,
`endif
    output logic          done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = AW / 2 + 1;
    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic signed [CW-1:0] X_MAX = CW'(IMG_W - 1);
    localparam logic signed [CW-1:0] Y_MAX = CW'(IMG_H - 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

    // Returns {pad, addr}. Padding taps point at the centre pixel so the address never wraps.
    function automatic logic [AW:0] tap_lookup(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                               input logic [3:0] k);
        logic signed [CW-1:0] dy, dx, yy, xx;
        logic                 in_b;
        if (k < 4'd3)      dy = '1;
        else if (k < 4'd6) dy = '0;
        else               dy = CW'(1);
        case (k)
            4'd0, 4'd3, 4'd6: dx = '1;
            4'd1, 4'd4, 4'd7: dx = '0;
            default:          dx = CW'(1);
        endcase
        yy   = CW'(y) + dy;
        xx   = CW'(x) + dx;
        in_b = !yy[CW-1] && (yy <= Y_MAX) && !xx[CW-1] && (xx <= X_MAX);
        return in_b ? {1'b0, AW'({yy[YW-1:0], xx[XW-1:0]})} : {1'b1, AW'({y, x})};
    endfunction

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [3:0]      k_q, k_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [AW-1:0]   iaddr_q, iaddr_d, res_addr_q, res_addr_d;
    logic [3:0]      tap_idx_q, tap_idx_d;
    logic            tap_valid_q, tap_valid_d, tap_zero_q, tap_zero_d, acc_clr_q, acc_clr_d;
    logic            wr_req_q, wr_req_d, busy_q, busy_d, done_q, done_d;
    logic [AW:0]     tap;
`ifdef CONV_SCHED_PERF_EN
    logic [15:0]     perf_stall_q, perf_stall_d;
`endif

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = FETCH;
                x_d     = '0;
                y_d     = '0;
                k_d     = '0;
            end
            FETCH: if (k_q == 4'd8) begin
                state_d = DRAIN;
                dcnt_d  = '0;
            end else begin
                k_d = k_q + 4'd1;
            end
            DRAIN: if (dcnt_q == DW'(MAC_LAT - 1)) state_d = WRITE;
                   else dcnt_d = dcnt_q + 1'b1;
            WRITE: if (wr_gnt) begin
                x_d     = x_q + 1'b1;
                k_d     = '0;
                if (x_q == X_LAST) y_d = y_q + 1'b1;
                state_d = (x_q == X_LAST && y_q == Y_LAST) ? DONE : FETCH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are computed from the next state so they can be registered without lag.
        tap         = tap_lookup(x_d, y_d, k_d);
        tap_valid_d = (state_d == FETCH);
        tap_idx_d   = tap_valid_d ? k_d : 4'd0;
        tap_zero_d  = tap_valid_d & tap[AW];
        iaddr_d     = tap_valid_d ? tap[AW-1:0] : '0;
        acc_clr_d   = tap_valid_d && (k_d == 4'd0);
        wr_req_d    = (state_d == WRITE);
        res_addr_d  = wr_req_d ? AW'({y_d, x_d}) : '0;
        busy_d      = state_d inside {FETCH, DRAIN, WRITE};
        done_d      = (state_d == DONE);

`ifdef CONV_SCHED_PERF_EN
        perf_stall_d = perf_stall_q;
        if (state_q == IDLE && start)
            perf_stall_d = '0;
        else if (state_q == WRITE && !wr_gnt && perf_stall_q != 16'hFFFF)
            perf_stall_d = perf_stall_q + 16'd1;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            k_q         <= '0;
            dcnt_q      <= '0;
            iaddr_q     <= '0;
            tap_valid_q <= 1'b0;
            tap_zero_q  <= 1'b0;
            tap_idx_q   <= '0;
            acc_clr_q   <= 1'b0;
            wr_req_q    <= 1'b0;
            res_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CONV_SCHED_PERF_EN
            perf_stall_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            k_q         <= k_d;
            dcnt_q      <= dcnt_d;
            iaddr_q     <= iaddr_d;
            tap_valid_q <= tap_valid_d;
            tap_zero_q  <= tap_zero_d;
            tap_idx_q   <= tap_idx_d;
            acc_clr_q   <= acc_clr_d;
            wr_req_q    <= wr_req_d;
            res_addr_q  <= res_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef CONV_SCHED_PERF_EN
            perf_stall_q <= perf_stall_d;
`endif
        end
    end

    assign iaddr     = iaddr_q;
    assign tap_valid = tap_valid_q;
    assign tap_zero  = tap_zero_q;
    assign tap_idx   = tap_idx_q;
    assign acc_clr   = acc_clr_q;
    assign wr_req    = wr_req_q;
    assign res_addr  = res_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef CONV_SCHED_PERF_EN
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_conv_window_sched.sv
// Self-checking bench for conv_window_sched: a pixel/phase reference model compared every cycle,
// plus directed literal checks at the image corners, write stalls, frame length and mid-frame reset.
module tb_conv_window_sched;

    localparam int W = 64;
    localparam int H = 64;
    localparam int N = W * H;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n, start, wr_gnt;
    logic [11:0] iaddr, res_addr;
    logic        tap_valid, tap_zero, acc_clr, wr_req, busy, done;
    logic [3:0]  tap_idx;
`ifdef CONV_SCHED_PERF_EN
    logic [15:0] perf_stall;
`endif

    conv_window_sched #(.IMG_W(W), .IMG_H(H), .AW(12), .MAC_LAT(L)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .wr_gnt    (wr_gnt),
        .iaddr     (iaddr),
        .tap_valid (tap_valid),
        .tap_zero  (tap_zero),
        .tap_idx   (tap_idx),
        .acc_clr   (acc_clr),
        .wr_req    (wr_req),
        .res_addr  (res_addr),
        .busy      (busy),
`ifdef CONV_SCHED_PERF_EN
        .perf_stall(perf_stall),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference tap: neighbour of pixel p for tap k, padded to the centre address when off-image.
    function automatic void exp_tap(input int p, input int k, output bit z, output int a);
        int x, y, xx, yy;
        x  = p % W;
        y  = p / W;
        yy = y + k / 3 - 1;
        xx = x + k % 3 - 1;
        if (yy >= 0 && yy < H && xx >= 0 && xx < W) begin
            z = 1'b0;
            a = yy * W + xx;
        end else begin
            z = 1'b1;
            a = p;
        end
    endfunction

    // Model: pixel index and phase within the pixel (0..8 taps, then drain, then write).
    bit m_active, m_done;
    int m_p, m_c, m_stall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_p      <= 0;
            m_c      <= 0;
            m_stall  <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_p      <= 0;
                m_c      <= 0;
                m_stall  <= 0;
            end
        end else if (m_c < 9 + L) begin
            m_c <= m_c + 1;
        end else if (wr_gnt) begin
            if (m_p == N - 1) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end else begin
                m_p <= m_p + 1;
                m_c <= 0;
            end
        end else if (m_stall < 65535) begin
            m_stall <= m_stall + 1;
        end
    end

    bit          e_tv, e_wr, e_z;
    int          e_a;
    logic [33:0] e_vec, a_vec;

    always @(negedge clk) begin
        e_tv = m_active && (m_c < 9);
        e_wr = m_active && (m_c == 9 + L);
        e_z  = 1'b0;
        e_a  = 0;
        if (e_tv) exp_tap(m_p, m_c, e_z, e_a);
        e_vec = {e_tv, e_tv ? 4'(m_c) : 4'd0, e_z, 12'(e_a), e_tv && (m_c == 0), e_wr,
                 e_wr ? 12'(m_p) : 12'd0, m_active, m_done};
        a_vec = {tap_valid, e_tv ? tap_idx : 4'd0, e_tv ? tap_zero : 1'b0, e_tv ? iaddr : 12'd0,
                 acc_clr, wr_req, e_wr ? res_addr : 12'd0, busy, done};
        check("cycle", 64'(a_vec), 64'(e_vec));
`ifdef CONV_SCHED_PERF_EN
        check("perf_stall_cycle", 64'(perf_stall), 64'(m_stall));
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    // Assumes wr_gnt=1 from the start edge (cyc=1) so pixel p's tap 0 appears at cyc 1+12p.
    task automatic check_pixel(input int p, input bit [8:0] ez, input int ea[9]);
        while (cyc < 1 + 12 * p) tick();
        for (int k = 0; k < 9; k++) begin
            check($sformatf("px%0d_k%0d", p, k), {tap_valid, tap_idx, tap_zero, acc_clr, iaddr},
                  {1'b1, 4'(k), ez[k], k == 0, 12'(ea[k])});
            if (k < 8) tick();
        end
    endtask

    function automatic logic [33:0] all_outs();
        return {iaddr, tap_valid, tap_zero, tap_idx, acc_clr, wr_req, res_addr, busy, done};
    endfunction

    int done_cyc, extra;

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        wr_gnt = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_outputs", 64'(all_outs()), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", {busy, done}, 2'b00);

        // Frame with wr_gnt tied high.
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
        check_pixel(0, 9'b001001111, '{0, 0, 0, 0, 0, 1, 0, 64, 65});
        while (cyc < 12) tick();
        check("px0_write", {wr_req, res_addr}, {1'b1, 12'd0});
        check_pixel(65, 9'b000000000, '{0, 1, 2, 64, 65, 66, 128, 129, 130});
        while (cyc < 3000) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_pixel(4095, 9'b111100100, '{4030, 4031, 4095, 4094, 4095, 4095, 4095, 4095, 4095});
        while (cyc < 49152) tick();
        check("px4095_write", {wr_req, res_addr}, {1'b1, 12'd4095});
        done_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check("frame_len", 64'(done_cyc - 1), 64'(N * 12));
        check("done_busy", {done, busy}, 2'b10);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) extra++;
        end
        check("done_once", 64'(extra), 64'd0);
        check("idle_after", {busy, tap_valid, wr_req}, 3'b000);

        // Write stall: grant withheld for three cycles on pixel 0.
        wr_gnt = 1'b0;
        start  = 1'b1;
        cyc    = 0;
        tick();
        start = 1'b0;
        while (cyc < 12) tick();
        check("stall_req", {wr_req, res_addr}, {1'b1, 12'd0});
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_hold%0d", i), {wr_req, res_addr, tap_valid}, {1'b1, 12'd0, 1'b0});
        end
        wr_gnt = 1'b1;
        tick();
        check("after_grant", {wr_req, tap_valid, tap_idx, tap_zero, iaddr},
              {1'b0, 1'b1, 4'd0, 1'b1, 12'd1});
`ifdef CONV_SCHED_PERF_EN
        check("perf_stall_3", 64'(perf_stall), 64'd3);
`endif

        // Reset in the middle of pixel 100's fetch.
        while (cyc < 1208) tick();
        check("px100_k4", {tap_valid, tap_idx, iaddr}, {1'b1, 4'd4, 12'd100});
        #1 rst_n = 1'b0;
        #1 check("reset_abort", 64'(all_outs()), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_after_abort", {busy, tap_valid, wr_req}, 3'b000);
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
        check("restart_k0", {tap_valid, tap_idx, tap_zero, acc_clr, iaddr},
              {1'b1, 4'd0, 1'b1, 1'b1, 12'd0});
        while (cyc < 5) tick();
        check("restart_k4", {tap_idx, tap_zero, iaddr}, {4'd4, 1'b0, 12'd0});
        tick();
        check("restart_k5", {tap_idx, tap_zero, iaddr}, {4'd5, 1'b0, 12'd1});
        while (cyc < 40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
